// File: rtl/sequenciador_calculadora.sv
// Sequencer in front of the 8-bit combinational calculator. It collects A, B and the code
// as a valid/ready byte stream, holds them on the calculator and returns the registered result.
module sequenciador_calculadora #(
  parameter int ENCADEIA       = 0,
  parameter int TIMEOUT_CICLOS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_dado,
  input  logic       in_valido,
  output logic       in_pronto,
  output logic [7:0] calc_A,
  output logic [7:0] calc_B,
  output logic [2:0] calc_codigo,
  input  logic [7:0] calc_saida,
  output logic [7:0] out_resultado,
  output logic       out_codigo_invalido,
  output logic       out_valido,
  input  logic       out_pronto,
  output logic       erro_timeout
);
  localparam int            CW          = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX     = CW'((TIMEOUT_CICLOS > 0) ? TIMEOUT_CICLOS - 1 : 0);
  localparam bit            TEM_TIMEOUT = (TIMEOUT_CICLOS > 0);
  localparam bit            ENCADEADO   = (ENCADEIA != 0);

  typedef enum logic [2:0] {ESPERA_A, ESPERA_B, ESPERA_COD, CALCULA, ENTREGA} estado_t;

  typedef struct packed {
    logic [7:0] resultado;
    logic       invalido;
  } resp_t;

  estado_t       estado, estado_d;
  logic [7:0]    a_d, b_d;
  logic [2:0]    cod_d;
  logic          flag_q, flag_d;
  resp_t         resp_q, resp_d;
  logic          ov_d, erro_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          in_xfer, out_xfer, cod_ok, ocioso, expira;

  assign in_pronto           = (estado == ESPERA_A) || (estado == ESPERA_B) || (estado == ESPERA_COD);
  assign in_xfer             = in_valido & in_pronto;
  assign out_xfer            = out_valido & out_pronto;
  assign out_resultado       = resp_q.resultado;
  assign out_codigo_invalido = resp_q.invalido;
  assign cod_ok              = (in_dado[7:3] == 5'd0) && (in_dado[2:0] <= 3'b100);

  // Only the B and code waits are guarded; ENTREGA may stall forever.
  assign ocioso = TEM_TIMEOUT && ((estado == ESPERA_B) || (estado == ESPERA_COD)) && !in_valido;
  assign expira = ocioso && (cnt == CNT_MAX);

  always_comb begin
    cnt_d = '0;
    if (ocioso && !expira) cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= ESPERA_A;
      calc_A       <= '0;
      calc_B       <= '0;
      calc_codigo  <= '0;
      flag_q       <= 1'b0;
      resp_q       <= '0;
      out_valido   <= 1'b0;
      erro_timeout <= 1'b0;
      cnt          <= '0;
    end else begin
      estado       <= estado_d;
      calc_A       <= a_d;
      calc_B       <= b_d;
      calc_codigo  <= cod_d;
      flag_q       <= flag_d;
      resp_q       <= resp_d;
      out_valido   <= ov_d;
      erro_timeout <= erro_d;
      cnt          <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado;
    a_d      = calc_A;
    b_d      = calc_B;
    cod_d    = calc_codigo;
    flag_d   = flag_q;
    resp_d   = resp_q;
    ov_d     = out_valido;
    erro_d   = 1'b0;
    case (estado)
      ESPERA_A: begin
        if (in_xfer) begin
          a_d      = in_dado;
          estado_d = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (in_xfer) begin
          b_d      = in_dado;
          estado_d = ESPERA_COD;
        end else if (expira) begin
          estado_d = ESPERA_A;
          erro_d   = 1'b1;
        end
      end
      ESPERA_COD: begin
        if (in_xfer) begin
          // An illegal code still runs the calculator, on the harmless code 000.
          cod_d    = cod_ok ? in_dado[2:0] : 3'b000;
          flag_d   = !cod_ok;
          estado_d = CALCULA;
        end else if (expira) begin
          estado_d = ESPERA_A;
          erro_d   = 1'b1;
        end
      end
      CALCULA: begin
        resp_d.resultado = calc_saida;
        resp_d.invalido  = flag_q;
        ov_d             = 1'b1;
        estado_d         = ENTREGA;
      end
      ENTREGA: begin
        if (out_xfer) begin
          ov_d = 1'b0;
          if (ENCADEADO) begin
            a_d      = resp_q.resultado;
            estado_d = ESPERA_B;
          end else begin
            estado_d = ESPERA_A;
          end
        end
      end
      default: estado_d = ESPERA_A;
    endcase
  end

  a_ov_held: assert property (@(posedge clk) disable iff (!rst_n)
    out_valido && !out_pronto |=> out_valido && $stable(out_resultado) && $stable(out_codigo_invalido));
  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(in_pronto && out_valido));
  a_pulse: assert property (@(posedge clk) disable iff (!rst_n) erro_timeout |=> !erro_timeout);

endmodule

// File: tb/tb_sequenciador_calculadora.sv
// Random and directed checks of the calculator sequencer: one plain instance with a 4-cycle
// timeout and one chained instance, each driving a behavioural model of the calculator.
module tb_sequenciador_calculadora;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      vin, op;
  logic [1:0][7:0] din;
  wire  [1:0]      rdy, ov, inv, et;
  wire  [1:0][7:0] ca, cb, cs, res;
  wire  [1:0][2:0] cc;
  int              n_chk = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  // The external calculator: 000 zero, 001 A, 010 B, 011 A+B, 100 A-B.
  function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    case (c)
      3'd1:    return a;
      3'd2:    return b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      default: return 8'd0;
    endcase
  endfunction

  assign cs[0] = calc_fn(ca[0], cb[0], cc[0]);
  assign cs[1] = calc_fn(ca[1], cb[1], cc[1]);

  // Expected result from the raw code byte; anything above 4 is illegal and yields 0.
  function automatic int ref_res(input int a, input int b, input int cbyte);
    case (cbyte)
      1:       return a;
      2:       return b;
      3:       return (a + b) % 256;
      4:       return (a - b + 256) % 256;
      default: return 0;
    endcase
  endfunction

  sequenciador_calculadora #(.ENCADEIA(0), .TIMEOUT_CICLOS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_dado(din[0]), .in_valido(vin[0]), .in_pronto(rdy[0]),
    .calc_A(ca[0]), .calc_B(cb[0]), .calc_codigo(cc[0]), .calc_saida(cs[0]),
    .out_resultado(res[0]), .out_codigo_invalido(inv[0]), .out_valido(ov[0]),
    .out_pronto(op[0]), .erro_timeout(et[0]));

  sequenciador_calculadora #(.ENCADEIA(1), .TIMEOUT_CICLOS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_dado(din[1]), .in_valido(vin[1]), .in_pronto(rdy[1]),
    .calc_A(ca[1]), .calc_B(cb[1]), .calc_codigo(cc[1]), .calc_saida(cs[1]),
    .out_resultado(res[1]), .out_codigo_invalido(inv[1]), .out_valido(ov[1]),
    .out_pronto(op[1]), .erro_timeout(et[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Holds the byte until it is taken; returns 1 time unit after the accepting edge.
  task automatic put(input int s, input logic [7:0] b);
    int n;
    n = 0;
    vin[s] = 1'b1;
    din[s] = b;
    while (!rdy[s] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("put_wait", rdy[s], 1);
    tick();
    vin[s] = 1'b0;
  endtask

  task automatic get(input int s, input logic [7:0] er, input logic ei, input int stall);
    int n;
    n = 0;
    while (!ov[s] && n < 40) begin
      tick();
      n++;
    end
    chk("ov", ov[s], 1);
    chk("res", res[s], er);
    chk("inv", inv[s], ei);
    repeat (stall) begin
      tick();
      chk("hold_ov", ov[s], 1);
      chk("hold_res", res[s], er);
    end
    op[s] = 1'b1;
    tick();
    op[s] = 1'b0;
    chk("ov_drop", ov[s], 0);
  endtask

  task automatic run_op(input int s, input bit send_a, input int a, input int b, input int c, input int stall);
    if (send_a) begin
      put(s, 8'(a));
      gap();
    end
    put(s, 8'(b));
    gap();
    put(s, 8'(c));
    get(s, 8'(ref_res(a, b, c)), (c > 4), stall);
  endtask

  function automatic int rand_code();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int acc, b, c, e;
    rst_n = 1'b0;
    vin   = '0;
    op    = '0;
    din   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ca", ca[s], 0);
      chk("rst_cb", cb[s], 0);
      chk("rst_cc", cc[s], 0);
      chk("rst_res", res[s], 0);
      chk("rst_ov", ov[s], 0);
      chk("rst_inv", inv[s], 0);
      chk("rst_et", et[s], 0);
      chk("rst_rdy", rdy[s], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency and minimum period with the sink always ready.
    op[0] = 1'b1;
    put(0, 8'd200);
    put(0, 8'd100);
    put(0, 8'd3);
    chk("lat_calc_ov", ov[0], 0);
    chk("lat_calc_rdy", rdy[0], 0);
    tick();
    chk("lat_ov", ov[0], 1);
    chk("lat_res", res[0], 44);
    chk("lat_inv", inv[0], 0);
    tick();
    chk("period_ov", ov[0], 0);
    chk("period_rdy", rdy[0], 1);
    op[0] = 1'b0;

    run_op(0, 1, 5, 9, 4, 0);
    run_op(0, 1, 5, 9, 1, 0);
    run_op(0, 1, 5, 9, 2, 1);
    run_op(0, 1, 5, 9, 0, 0);
    run_op(0, 1, 5, 9, 8'h07, 0);
    run_op(0, 1, 5, 9, 8'h0B, 2);

    // Ten-cycle stall with junk offered on the input.
    put(0, 8'd5);
    put(0, 8'd9);
    put(0, 8'd3);
    tick();
    vin[0] = 1'b1;
    din[0] = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rdy", rdy[0], 0);
      chk("stall_ov", ov[0], 1);
      chk("stall_res", res[0], 14);
      chk("stall_ca", ca[0], 5);
    end
    vin[0] = 1'b0;
    op[0]  = 1'b1;
    tick();
    op[0]  = 1'b0;
    chk("stall_drop", ov[0], 0);
    run_op(0, 1, 1, 2, 3, 0);

    // Timeout: A then four idle cycles.
    put(0, 8'd33);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_err", et[0], (i == 4));
    end
    chk("to_rdy", rdy[0], 1);
    tick();
    chk("to_pulse_end", et[0], 0);
    chk("to_ca_kept", ca[0], 33);
    run_op(0, 1, 7, 2, 3, 0);

    // A byte on the expiry cycle wins; each transfer restarts the count.
    put(0, 8'd50);
    repeat (3) tick();
    put(0, 8'd60);
    chk("tw_err_b", et[0], 0);
    repeat (3) tick();
    put(0, 8'd3);
    chk("tw_err_c", et[0], 0);
    get(0, 8'd110, 1'b0, 0);

    for (int i = 0; i < 30; i++)
      run_op(0, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rand_code(),
             int'($urandom_range(0, 3)));

    // Chained instance: the result feeds back as A.
    run_op(1, 1, 10, 3, 3, 0);
    chk("chain_a1", ca[1], 13);
    chk("chain_rdy", rdy[1], 1);
    run_op(1, 0, 13, 4, 4, 1);
    chk("chain_a2", ca[1], 9);
    acc = 9;
    for (int i = 0; i < 15; i++) begin
      b = int'($urandom_range(0, 255));
      c = rand_code();
      e = ref_res(acc, b, c);
      run_op(1, 0, acc, b, c, int'($urandom_range(0, 2)));
      acc = e;
      chk("chain_a", ca[1], acc);
    end

    // Reset while the calculator cycle is in flight.
    put(0, 8'd200);
    put(0, 8'd100);
    put(0, 8'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_ca", ca[0], 0);
    chk("mid_cb", cb[0], 0);
    chk("mid_cc", cc[0], 0);
    chk("mid_res", res[0], 0);
    chk("mid_ov", ov[0], 0);
    chk("mid_inv", inv[0], 0);
    chk("mid_rdy", rdy[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(0, 1, 3, 4, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
